// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared types and constants for the machine trap controller
//
// Purpose : FSM state encoding, exception/interrupt cause codes, bit positions
//           inside expt_i / irq_i, mstatus field indices and mtvec mode values.
// Ports   : none (package)

package clint_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP_WR  = 2'd1,
    MRET_WR  = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  // Width of the cause code field carried between arbiter and top.
  localparam int CODE_W = 4;

  // Synchronous exception cause codes (mcause MSB = 0).
  localparam logic [CODE_W-1:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [CODE_W-1:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [CODE_W-1:0] CAUSE_ECALL   = 4'd11;

  // Interrupt cause codes (mcause MSB = 1); also the mie bit index of each source.
  localparam logic [CODE_W-1:0] IRQ_MSI_CODE = 4'd3;
  localparam logic [CODE_W-1:0] IRQ_MTI_CODE = 4'd7;
  localparam logic [CODE_W-1:0] IRQ_MEI_CODE = 4'd11;

  // expt_i = {illegal, ecall, ebreak, mret}
  localparam int EXPT_ILLEGAL = 3;
  localparam int EXPT_ECALL   = 2;
  localparam int EXPT_EBREAK  = 1;
  localparam int EXPT_MRET    = 0;

  // irq_i = {mei, msi, mti}
  localparam int IRQ_MEI_BIT = 2;
  localparam int IRQ_MSI_BIT = 1;
  localparam int IRQ_MTI_BIT = 0;

  // mstatus fields
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mtvec.MODE encodings
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/clint_irq_arb.sv
// rtl/clint_irq_arb.sv - combinational priority encoder for exceptions, interrupts and mret
//
// Purpose : picks the single highest-priority event offered by IDU this cycle.
//           illegal > ecall > ebreak > MEI > MSI > MTI > mret.
// Ports   : valid        in   IDU instruction valid
//           expt         in   {illegal, ecall, ebreak, mret}
//           irq          in   {mei, msi, mti} pending levels
//           mie          in   mie CSR (bits 11/3/7 used)
//           mstatus_mie  in   global machine interrupt enable
//           take         out  an exception or interrupt is to be taken
//           is_int       out  the taken event is an interrupt
//           code         out  cause code of the taken event
//           is_mret      out  mret is to be executed (nothing higher pending)

module clint_irq_arb
  import clint_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              valid,
  input  logic [3:0]        expt,
  input  logic [2:0]        irq,
  input  logic [XLEN-1:0]   mie,
  input  logic              mstatus_mie,
  output logic              take,
  output logic              is_int,
  output logic [CODE_W-1:0] code,
  output logic              is_mret
);

  logic irq_mei;
  logic irq_msi;
  logic irq_mti;

  // An interrupt is only eligible when globally enabled, locally enabled and pending.
  assign irq_mei = mstatus_mie & mie[IRQ_MEI_CODE] & irq[IRQ_MEI_BIT];
  assign irq_msi = mstatus_mie & mie[IRQ_MSI_CODE] & irq[IRQ_MSI_BIT];
  assign irq_mti = mstatus_mie & mie[IRQ_MTI_CODE] & irq[IRQ_MTI_BIT];

  // Only three mie bits matter here.
  logic unused_mie;
  assign unused_mie = ^{mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0]};

  always_comb begin
    take    = 1'b0;
    is_int  = 1'b0;
    code    = '0;
    is_mret = 1'b0;
    if (valid) begin
      if (expt[EXPT_ILLEGAL]) begin
        take = 1'b1;
        code = CAUSE_ILLEGAL;
      end else if (expt[EXPT_ECALL]) begin
        take = 1'b1;
        code = CAUSE_ECALL;
      end else if (expt[EXPT_EBREAK]) begin
        take = 1'b1;
        code = CAUSE_EBREAK;
      end else if (irq_mei) begin
        take   = 1'b1;
        is_int = 1'b1;
        code   = IRQ_MEI_CODE;
      end else if (irq_msi) begin
        take   = 1'b1;
        is_int = 1'b1;
        code   = IRQ_MSI_CODE;
      end else if (irq_mti) begin
        take   = 1'b1;
        is_int = 1'b1;
        code   = IRQ_MTI_CODE;
      end else if (expt[EXPT_MRET]) begin
        is_mret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clint_trap_ctrl.sv
// rtl/clint_trap_ctrl.sv - machine-mode trap/return controller with CSR writes and PC redirect
//
// Purpose : takes exceptions, interrupts and mret from IDU, writes mepc/mcause/
//           mtval/mstatus for one cycle, then requests an IF redirect and holds
//           the pipeline until IF accepts it.
// Ports   : clk, rst_n                  clock, async active-low reset
//           inst_valid_i, pc_i          instruction in IDU and its PC
//           jump_i, jump_pc_i           taken jump and its target (interrupt epc)
//           expt_i, expt_tval_i         {illegal, ecall, ebreak, mret}, illegal bits
//           irq_i                       {mei, msi, mti} level-sensitive pending
//           csr_mie_i .. csr_mepc_i     current machine CSR values
//           *_wen_o / *_wdata_o         one-cycle CSR write strobes and data
//           redirect_valid_o/addr_o     PC redirect request to IF
//           redirect_ready_i            IF accepts the redirect
//           hold_o                      pipeline stall request

module clint_trap_ctrl
  import clint_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter bit              VECTORED_EN = 1'b1,
  parameter logic [XLEN-1:0] RESET_VEC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_pc_i,
  input  logic [3:0]      expt_i,
  input  logic [XLEN-1:0] expt_tval_i,
  input  logic [2:0]      irq_i,
  input  logic [XLEN-1:0] csr_mie_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            mepc_wen_o,
  output logic [XLEN-1:0] mepc_wdata_o,
  output logic            mcause_wen_o,
  output logic [XLEN-1:0] mcause_wdata_o,
  output logic            mtval_wen_o,
  output logic [XLEN-1:0] mtval_wdata_o,
  output logic            mstatus_wen_o,
  output logic [XLEN-1:0] mstatus_wdata_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_addr_o,
  input  logic            redirect_ready_i,
  output logic            hold_o
);

  state_t state;
  state_t state_nxt;

  logic              take;
  logic              is_int;
  logic              is_mret;
  logic [CODE_W-1:0] code;

  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] target_q;

  logic [XLEN-1:0] epc_val;
  logic [XLEN-1:0] cause_val;
  logic [XLEN-1:0] tval_val;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] tvec_off;
  logic [XLEN-1:0] trap_target;
  logic            use_vectored;
  logic            event_idle;

  clint_irq_arb #(
    .XLEN (XLEN)
  ) u_arb (
    .valid       (inst_valid_i),
    .expt        (expt_i),
    .irq         (irq_i),
    .mie         (csr_mie_i),
    .mstatus_mie (csr_mstatus_i[MSTATUS_MIE]),
    .take        (take),
    .is_int      (is_int),
    .code        (code),
    .is_mret     (is_mret)
  );

  // Interrupts resume at the jump target when the interrupted instruction was
  // a taken jump, so the jump is not lost; exceptions always report pc_i.
  assign epc_val   = (is_int && jump_i) ? jump_pc_i : pc_i;
  assign cause_val = {is_int, {(XLEN-CODE_W-1){1'b0}}, code};
  assign tval_val  = (take && !is_int && code == CAUSE_ILLEGAL) ? expt_tval_i : '0;

  assign tvec_base    = {csr_mtvec_i[XLEN-1:2], 2'b00};
  assign tvec_off     = {{(XLEN-CODE_W-2){1'b0}}, code, 2'b00};
  assign use_vectored = VECTORED_EN && (csr_mtvec_i[1:0] == MTVEC_MODE_VECTORED) && is_int;
  assign trap_target  = use_vectored ? (tvec_base + tvec_off) : tvec_base;

  // Events are only looked at in IDLE; anything offered while busy is dropped.
  assign event_idle = (state == IDLE) && (take || is_mret);
  assign hold_o     = event_idle || (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = TRAP_WR;
        end else if (is_mret) begin
          state_nxt = MRET_WR;
        end
      end
      TRAP_WR:  state_nxt = REDIRECT;
      MRET_WR:  state_nxt = REDIRECT;
      REDIRECT: begin
        if (redirect_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (take) begin
          epc_q    <= epc_val;
          cause_q  <= cause_val;
          tval_q   <= tval_val;
          target_q <= trap_target;
        end else if (is_mret) begin
          target_q <= csr_mepc_i;
        end
      end
    end
  end

  // CSR strobes and redirect are decoded from the state alone, so an async
  // reset clears every output in the same instant.
  logic [XLEN-1:0] mstatus_new;

  always_comb begin
    mepc_wen_o       = 1'b0;
    mepc_wdata_o     = '0;
    mcause_wen_o     = 1'b0;
    mcause_wdata_o   = '0;
    mtval_wen_o      = 1'b0;
    mtval_wdata_o    = '0;
    mstatus_wen_o    = 1'b0;
    mstatus_wdata_o  = '0;
    redirect_valid_o = 1'b0;
    redirect_addr_o  = RESET_VEC;
    mstatus_new      = csr_mstatus_i;
    case (state)
      TRAP_WR: begin
        mstatus_new[MSTATUS_MPIE]                  = csr_mstatus_i[MSTATUS_MIE];
        mstatus_new[MSTATUS_MIE]                   = 1'b0;
        mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mepc_wen_o      = 1'b1;
        mepc_wdata_o    = epc_q;
        mcause_wen_o    = 1'b1;
        mcause_wdata_o  = cause_q;
        mtval_wen_o     = 1'b1;
        mtval_wdata_o   = tval_q;
        mstatus_wen_o   = 1'b1;
        mstatus_wdata_o = mstatus_new;
      end
      MRET_WR: begin
        mstatus_new[MSTATUS_MIE]                   = csr_mstatus_i[MSTATUS_MPIE];
        mstatus_new[MSTATUS_MPIE]                  = 1'b1;
        mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_wen_o   = 1'b1;
        mstatus_wdata_o = mstatus_new;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_addr_o  = target_q;
      end
      default: ;
    endcase
  end

endmodule
